// File: rtl/rx_pkg.sv
// Shared FSM encoding and status-tag bit positions for the UART receive buffer.
package rx_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_STOP   = 3'd3;
  localparam state_t ST_PARITY = 3'd4;

  // Bit positions inside the {full, empty} status tag.
  localparam int TAG_EMPTY = 0;
  localparam int TAG_FULL  = 1;

endpackage

// File: rtl/rx_fifo_savemod.sv
// Byte FIFO for received characters: push visible next cycle, head shown combinationally.
// A push while full is accepted only alongside a pop; otherwise it is dropped and drop_o pulses.
module rx_fifo_savemod
  import rx_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     CLOCK,
  input  logic                     RESET,
  input  logic                     push_i,
  input  logic [7:0]               push_dat_i,
  input  logic                     pop_i,
  output logic [7:0]               head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [1:0]               tag_o,
  output logic                     drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full, empty, wr_en, rd_en;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // A full buffer still takes a byte when the same cycle frees a slot.
  assign wr_en  = push_i && (!full || pop_i);
  assign rd_en  = pop_i && !empty;
  assign drop_o = push_i && full && !pop_i;

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_dat_i;
  end

  always_comb begin
    tag_o            = '0;
    tag_o[TAG_FULL]  = full;
    tag_o[TAG_EMPTY] = empty;
  end

  assign head_o  = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/rx_buffer_funcmod.sv
// UART receiver (8N1, or 8E1 with RX_PARITY_EN) feeding a DEPTH-byte FIFO; byte visible one cycle after stop midpoint.
// No backpressure on the line: a byte arriving while the FIFO is full is dropped and oOverrun latches.
module rx_buffer_funcmod
  import rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH        = 16
) (
  input  logic                   CLOCK,
  input  logic                   RESET,
  input  logic                   RXD,
  input  logic                   iRead,
  output logic [7:0]             oData,
  output logic [1:0]             oTag,
  output logic [$clog2(DEPTH):0] oCount,
  output logic                   oOverrun,
  output logic                   oFrameErr
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  logic          rxd_meta_q, rxd_sync_q, rxd_prev_q;
  state_t        state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q;
  logic          push, drop;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_meta_q <= RXD;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q + CW'(1);
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        clk_cnt_d = '0;
        if (rxd_prev_q && !rxd_sync_q) begin
          state_d   = ST_START;
          bit_cnt_d = '0;
        end
      end
      ST_START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          state_d   = rxd_sync_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rxd_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef RX_PARITY_EN
      ST_PARITY: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          // Even parity: data bits plus parity bit must XOR to zero.
          if (^{shift_q, rxd_sync_q}) begin
            frame_err_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_STOP;
          end
        end
      end
`endif
      ST_STOP: begin
        // Leave at the midpoint so a following start edge is not missed.
        if (clk_cnt_q == BIT_LAST) begin
          state_d     = ST_IDLE;
          push        = rxd_sync_q;
          frame_err_d = !rxd_sync_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_q | drop;
    end
  end

  rx_fifo_savemod #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .push_i     (push),
    .push_dat_i (shift_q),
    .pop_i      (iRead),
    .head_o     (oData),
    .count_o    (oCount),
    .tag_o      (oTag),
    .drop_o     (drop)
  );

  assign oOverrun  = overrun_q;
  assign oFrameErr = frame_err_q;

endmodule

// File: doc/rx_buffer_funcmod.md
RX_BUFFER_FUNCMOD -- requirements
Module: rx_buffer_funcmod

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, giving CLOCK cycles per serial bit (50 MHz / 115200 baud).
REQ-002 The block SHALL have parameter DEPTH, default 16, giving the receive buffer depth; it is a power of two, minimum 2.
REQ-003 The block SHALL have port CLOCK  input  1  the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port RXD  input  1  asynchronous serial line; idles high; 8N1 frames, LSB first.
REQ-006 The block SHALL have port iRead  input  1  one-cycle pop request from the consumer.
REQ-007 The block SHALL have port oData  output  8  head byte of the buffer, valid while oTag[0] is 0.
REQ-008 The block SHALL have port oTag  output  2  status {full, empty}.
REQ-009 The block SHALL have port oCount  output  $clog2(DEPTH)+1  number of bytes held.
REQ-010 The block SHALL have port oOverrun  output  1  sticky flag: a byte was dropped because the buffer was full.
REQ-011 The block SHALL have port oFrameErr  output  1  one-cycle pulse: a frame was rejected.

Function
REQ-012 RXD SHALL pass through a 2-flop synchronizer, reset to 1, before any use.
REQ-013 The FSM SHALL have states IDLE, START, DATA, STOP, plus PARITY when RX_PARITY_EN is defined.
REQ-014 IDLE: a 1->0 transition on synchronized RXD SHALL move the FSM to START and clear the bit counter.
REQ-015 START: at CLKS_PER_BIT/2 cycles the FSM SHALL resample; 0 -> DATA; 1 -> IDLE (false start, no error pulse).
REQ-016 DATA: the FSM SHALL sample every CLKS_PER_BIT cycles after the start midpoint and shift LSB first; after the 8th bit -> STOP (or PARITY).
REQ-017 STOP: at the stop-bit midpoint, 1 SHALL push the byte; 0 SHALL discard it, pulse oFrameErr and go to IDLE.
REQ-018 After the STOP sample the FSM SHALL return to IDLE immediately, without waiting for the end of the bit, so back-to-back frames resynchronize.
REQ-019 A pushed byte SHALL be visible the next cycle: oTag[0]=0, oData=head, oCount incremented.
REQ-020 iRead with the buffer non-empty SHALL pop the head; oData shows the next byte the following cycle; iRead on empty SHALL be ignored.
REQ-021 A push and a pop in the same cycle SHALL both take effect, at any fill level including full, with oCount unchanged.
REQ-022 A push to a full buffer without a simultaneous pop SHALL drop the byte and set oOverrun; contents stay unchanged.
REQ-023 Buffer pointers SHALL wrap modulo DEPTH; full = (oCount==DEPTH), empty = (oCount==0).

Reset
REQ-024 RESET SHALL force the FSM to IDLE, flush the buffer and set oData=0, oTag=2'b01, oCount=0, oOverrun=0, oFrameErr=0.
REQ-025 RESET asserted mid-frame SHALL abandon the frame; the remaining bits SHALL NOT be pushed.

Configuration
REQ-026 With macro RX_PARITY_EN defined, the block SHALL expect an even-parity bit after D7; on mismatch it SHALL discard the byte and pulse oFrameErr.
REQ-027 Without RX_PARITY_EN the block SHALL use 8N1 framing and contain no parity logic.

Structure
REQ-028 Shared package rx_pkg SHALL hold the FSM state typedef and the constants TAG_EMPTY=0 and TAG_FULL=1.
REQ-029 Buffer storage and pointers SHALL be in sub-module rx_fifo_savemod (push/pop in, data/count/tag out); the FSM stays in the top level.

Verification (CLKS_PER_BIT=16, DEPTH=4)
REQ-030 Frame 0x55 at 16 clk/bit -> oTag=2'b00 and oData=0x55 within 1 cycle after the stop midpoint; oCount=1.
REQ-031 A 6-cycle low glitch on idle RXD -> no push, no oFrameErr, FSM returns to IDLE.
REQ-032 Frame 0xA3 with stop bit 0 -> oFrameErr pulses exactly 1 cycle; oCount stays 0.
REQ-033 Five back-to-back frames 0x01..0x05 with no reads -> oTag=2'b10, oCount=4, oOverrun=1; reads return 0x01..0x04, then oTag=2'b01.
REQ-034 Full buffer, iRead asserted in the push cycle -> oCount stays 4, oOverrun stays 0, new byte at the tail.
REQ-035 RESET asserted at bit 4 of frame 0xFF, released, then frame 0x3C sent -> only 0x3C is received.
